output_uart_tx: RTL and testbench

//  Transmit half of the board's serial link. Accepts 32-bit words from the processor's output SPR
//  (one word per write strobe), buffers them, and serializes each as four 8N1 UART frames on a

---
 rtl/output_uart_pkg.sv | 9 +
 rtl/output_uart_tx_word_fifo.sv | 45 ++++
 rtl/output_uart_tx.sv | 143 ++++++++++++++
 tb/tb_output_uart_tx.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_uart_pkg.sv
// Shared types and constants for the output-SPR UART transmitter.
package output_uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam int BITS_PER_BYTE  = 8;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/output_uart_tx_word_fifo.sv
// Circular word buffer; pointers carry one extra wrap bit so full and empty are distinguishable.
module word_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             push_ok_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             pop_ok;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok    = pop_i && !empty_o;
   // A pop in the same cycle frees a slot, so a write on a full buffer still lands.
   assign push_ok_o = push_i && (!full_o || pop_ok);
   assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok_o) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)    rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/output_uart_tx.sv
// Output-SPR UART transmitter: buffers 32-bit words and sends each as four 8N1 frames, byte 0 first.
module output_uart_tx
   import output_uart_pkg::*;
#(
   parameter logic [15:0] CLKS_PER_BIT = 16'd5208,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic        clr_ovf,
   output logic        txd,
   output logic        tx_busy,
   output logic        fifo_full,
   output logic        fifo_empty,
   output logic        overflow
);

   localparam logic [15:0] BAUD_RELOAD = CLKS_PER_BIT - 16'd1;
   localparam logic [2:0]  LAST_BIT    = 3'(BITS_PER_BYTE - 1);
   localparam logic [1:0]  LAST_BYTE   = 2'(BYTES_PER_WORD - 1);

   tx_state_t   state_q;
   logic [15:0] baud_q;
   logic [2:0]  bit_idx_q;
   logic [1:0]  byte_idx_q;
   logic [31:0] shreg_q;
   logic        txd_q;
   logic        ovf_q;

   logic [31:0] fifo_rdata;
   logic        fifo_push_ok;
   logic        bit_end;
   logic        pop;
   logic        drop;

   word_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk),
      .rst_ni    (rst),
      .push_i    (wr_en),
      .pop_i     (pop),
      .wdata_i   (wr_data),
      .rdata_o   (fifo_rdata),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty),
      .push_ok_o (fifo_push_ok)
   );

   assign bit_end = (baud_q == 16'd0);
   // Pop from idle, or at the end of the last stop bit so consecutive words run gap-free.
   assign pop     = !fifo_empty &&
                    ((state_q == IDLE) ||
                     (state_q == STOP && bit_end && byte_idx_q == LAST_BYTE));
   assign drop    = wr_en && !fifo_push_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_idx_q  <= '0;
         byte_idx_q <= '0;
         shreg_q    <= '0;
         txd_q      <= 1'b1;
      end else begin
         // Line level follows the current state one cycle later; every bit keeps its full width.
         case (state_q)
            START:   txd_q <= 1'b0;
            DATA:    txd_q <= shreg_q[0];
            default: txd_q <= 1'b1;
         endcase

         case (state_q)
            IDLE: begin
               if (pop) begin
                  shreg_q    <= fifo_rdata;
                  byte_idx_q <= '0;
                  baud_q     <= BAUD_RELOAD;
                  state_q    <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  bit_idx_q <= '0;
                  baud_q    <= BAUD_RELOAD;
                  state_q   <= DATA;
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  shreg_q <= shreg_q >> 1;
                  baud_q  <= BAUD_RELOAD;
                  if (bit_idx_q == LAST_BIT) begin
                     state_q <= STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_q <= BAUD_RELOAD;
                  if (byte_idx_q != LAST_BYTE) begin
                     byte_idx_q <= byte_idx_q + 2'd1;
                     state_q    <= START;
                  end else if (pop) begin
                     shreg_q    <= fifo_rdata;
                     byte_idx_q <= '0;
                     state_q    <= START;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  baud_q <= baud_q - 16'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end else if (clr_ovf) begin
         ovf_q <= 1'b0;
      end
   end

   assign txd      = txd_q;
   assign tx_busy  = (state_q != IDLE) || !fifo_empty;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_output_uart_tx.sv
// Directed bench for output_uart_tx with CLKS_PER_BIT=4 and a 4-deep buffer.
module tb_output_uart_tx;

   localparam int CPB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        clr_ovf = 1'b0;
   logic        txd, tx_busy, fifo_full, fifo_empty, overflow;

   int checks = 0;
   int errors = 0;
   logic [7:0] rx_q [$];

   always #5 clk = ~clk;

   output_uart_tx #(
      .CLKS_PER_BIT (16'd4),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .clr_ovf    (clr_ovf),
      .txd        (txd),
      .tx_busy    (tx_busy),
      .fifo_full  (fifo_full),
      .fifo_empty (fifo_empty),
      .overflow   (overflow)
   );

   // Passive receiver: samples mid-bit, pushes each completed byte.
   initial begin : monitor
      int         cnt;
      bit         act;
      logic [9:0] fr;
      cnt = 0;
      act = 0;
      fr  = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            act = 0;
         end else if (!act) begin
            if (txd === 1'b0) begin
               act = 1;
               cnt = 0;
            end
         end else begin
            cnt++;
            if (cnt % CPB == CPB / 2) fr[cnt / CPB] = txd;
            if (cnt == 9 * CPB + CPB / 2) begin
               rx_q.push_back(fr[8:1]);
               act = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   function automatic logic exp_bit(input logic [31:0] w, input int n);
      int b, f, p;
      b = n / CPB;
      f = b / 10;
      p = b % 10;
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return w[8 * f + p - 1];
   endfunction

   task automatic do_write(input logic [31:0] d);
      wr_data = d;
      wr_en   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Caller sits on the negedge where the first start-bit sample is visible.
   task automatic check_stream(input logic [31:0] wa, input logic [31:0] wb,
                               input int nwords, input string nm);
      logic [39:0] obs, expv;
      logic [31:0] w;
      for (int f = 0; f < nwords * 4; f++) begin
         w = (f < 4) ? wa : wb;
         for (int s = 0; s < 40; s++) begin
            if (!(f == 0 && s == 0)) @(negedge clk);
            obs[s]  = txd;
            expv[s] = exp_bit(w, (f % 4) * 40 + s);
         end
         checks++;
         if (obs !== expv) begin
            errors++;
            $display("FAIL %s frame %0d: got %h want %h", nm, f, obs, expv);
         end
      end
   endtask

   task automatic wait_start(input int budget, input string nm);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (txd === 1'b0) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s start bit: none within %0d cycles", nm, budget);
      end
   endtask

   task automatic wait_idle(input int budget, input string nm);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx_busy === 1'b0) begin
            ok = 1;
            break;
         end
      end
      repeat (CPB) @(negedge clk);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s idle: tx_busy still high after %0d cycles", nm, budget);
      end
   endtask

   task automatic check_rx(input logic [31:0] w [$], input string nm);
      int bad;
      checks++;
      if (rx_q.size() != w.size() * 4) begin
         errors++;
         $display("FAIL %s byte count: got %0d want %0d", nm, rx_q.size(), w.size() * 4);
      end
      for (int i = 0; i < w.size(); i++) begin
         logic [31:0] got;
         bad = 0;
         got = '0;
         for (int b = 0; b < 4; b++) begin
            if (i * 4 + b < rx_q.size()) got[8 * b +: 8] = rx_q[i * 4 + b];
            else bad = 1;
         end
         checks++;
         if (bad != 0 || got !== w[i]) begin
            errors++;
            $display("FAIL %s word %0d: got %h want %h", nm, i, got, w[i]);
         end
      end
   endtask

   task automatic test_reset();
      bit stuck;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (txd !== 1'b1)        begin errors++; $display("FAIL reset txd: got %b want 1", txd); end
      checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL reset tx_busy: got %b want 0", tx_busy); end
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset fifo_empty: got %b want 1", fifo_empty); end
      checks++; if (fifo_full !== 1'b0)  begin errors++; $display("FAIL reset fifo_full: got %b want 0", fifo_full); end
      checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL reset overflow: got %b want 0", overflow); end
      rst = 1'b1;
      stuck = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) stuck = 1;
      end
      checks++; if (stuck) begin errors++; $display("FAIL reset idle line: got a 0 want constant 1"); end
   endtask

   task automatic test_single();
      rx_q.delete();
      do_write(32'hA55A_0F31);
      checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single busy after write: got %b want 1", tx_busy); end
      @(negedge clk);
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL single early start: got %b want 1", txd); end
      @(negedge clk);
      checks++; if (txd !== 1'b0) begin errors++; $display("FAIL single latency: got %b want 0", txd); end
      check_stream(32'hA55A_0F31, 32'h0, 1, "single");
      @(negedge clk);
      checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL single busy end: got %b want 0", tx_busy); end
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL single empty end: got %b want 1", fifo_empty); end
   endtask

   task automatic test_back_to_back();
      do_write(32'h0000_0001);
      do_write(32'hFFFF_FFFF);
      checks++; if (txd !== 1'b1) begin errors++; $display("FAIL b2b early start: got %b want 1", txd); end
      @(negedge clk);
      checks++; if (txd !== 1'b0) begin errors++; $display("FAIL b2b latency: got %b want 0", txd); end
      check_stream(32'h0000_0001, 32'hFFFF_FFFF, 2, "b2b");
      wait_idle(50, "b2b");
   endtask

   task automatic test_overflow();
      logic [31:0] w [$];
      w = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888, 32'h99AA_BBCC};
      rx_q.delete();
      for (int i = 0; i < 5; i++) do_write(w[i]);
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf full: got %b want 1", fifo_full); end
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL ovf early: got %b want 0", overflow); end
      do_write(32'hDEAD_BEEF);
      checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf set: got %b want 1", overflow); end
      wait_idle(1500, "ovf");
      check_rx(w, "ovf");
      checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL ovf sticky: got %b want 1", overflow); end
      clr_ovf = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL ovf clear: got %b want 0", overflow); end
   endtask

   task automatic test_full_pop();
      logic [31:0] w [$];
      w = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10, 32'h1112_1314, 32'hC0DE_F00D};
      rx_q.delete();
      for (int i = 0; i < 5; i++) do_write(w[i]);
      // First word popped one edge after its write; the next pop lands 160 edges later.
      repeat (156) @(negedge clk);
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fullpop pre full: got %b want 1", fifo_full); end
      do_write(w[5]);
      checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL fullpop overflow: got %b want 0", overflow); end
      checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL fullpop post full: got %b want 1", fifo_full); end
      wait_idle(2000, "fullpop");
      check_rx(w, "fullpop");
   endtask

   task automatic test_midreset();
      logic [31:0] w [$];
      rx_q.delete();
      do_write(32'h1234_5678);
      do_write(32'h9ABC_DEF0);
      wait_start(10, "midrst");
      repeat (97) @(negedge clk);
      checks++; if (txd !== 1'b0) begin errors++; $display("FAIL midrst pre txd: got %b want 0", txd); end
      #2 rst = 1'b0;
      #1;
      checks++; if (txd !== 1'b1)        begin errors++; $display("FAIL midrst async txd: got %b want 1", txd); end
      checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL midrst empty: got %b want 1", fifo_empty); end
      checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL midrst busy: got %b want 0", tx_busy); end
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rx_q.delete();
      w = '{32'hCAFE_BABE};
      do_write(w[0]);
      wait_idle(400, "midrst");
      check_rx(w, "midrst");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_full_pop();
      test_midreset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
